sparc_decode_hazard_stage: RTL and testbench

Parametrised successor to the single-instruction decode/interlock stage. It sits between fetch and execute.
- Holds one decoded SPARC V8 instruction in a valid/ready pipeline register.
- Classifies the instruction's register, icc and Y side-effects.
- Interlocks it against N_STAGES downstream writers, generalising the fixed IDEX/EXMem/MemWB checks.
- Pulses CWP update on SAVE/RESTORE issue. Adds flush, i-bit-aware rs2 checking and an optional stall counter.

---
 rtl/sparc_decode_pkg.sv | 45 ++++
 rtl/sparc_decode_classify.sv | 80 ++++++++
 rtl/sparc_decode_hazard_stage.sv | 154 +++++++++++++++
 tb/tb_sparc_decode_hazard_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_decode_pkg.sv
// Shared SPARC V8 decode constants and decode payload types.
// Holds op/op2/op3 encodings, the canonical NOP word, the decoded
// side-effect flag struct and the source-register list struct.
package sparc_decode_pkg;

  localparam int unsigned INST_BITS = 32;
  localparam int unsigned N_SRC     = 4;

  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam logic [5:0] OP3_LDD     = 6'b000011;
  localparam logic [5:0] OP3_STD     = 6'b000111;
  localparam logic [5:0] OP3_MULSCC  = 6'b100100;
  localparam logic [5:0] OP3_RDY     = 6'b101000;
  localparam logic [5:0] OP3_WRY     = 6'b110000;
  localparam logic [5:0] OP3_TICC    = 6'b111010;
  localparam logic [5:0] OP3_FLUSH   = 6'b111011;
  localparam logic [5:0] OP3_SAVE    = 6'b111100;
  localparam logic [5:0] OP3_RESTORE = 6'b111101;

  localparam logic [INST_BITS-1:0] NOP = 32'h0100_0000;

  typedef struct packed {
    logic       wr;
    logic       wr_dbl;
    logic       icc_wr;
    logic       y_wr;
    logic [4:0] rd;
  } decode_flags_t;

  // Slots: 0 = rs1, 1 = rs2, 2 = store data rd, 3 = STD odd half (rd^1)
  typedef struct packed {
    logic [N_SRC-1:0]      vld;
    logic [N_SRC-1:0][4:0] regs;
    logic                  icc_rd;
    logic                  y_rd;
  } src_list_t;

endpackage

// File: rtl/sparc_decode_classify.sv
// Combinational SPARC V8 instruction classifier.
// Ports:
//   inst_i  : 32-bit instruction word
//   flags_o : destination and side-effect flags (wr, wr_dbl, icc_wr, y_wr, rd)
//   src_o   : register sources plus icc/Y read requirements
module sparc_decode_classify
  import sparc_decode_pkg::*;
(
  input  logic [INST_BITS-1:0] inst_i,
  output decode_flags_t        flags_o,
  output src_list_t            src_o
);

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       imm;
  logic       is_store;
  logic       unused_bits;

  assign op          = inst_i[31:30];
  assign rd          = inst_i[29:25];
  assign op2         = inst_i[24:22];
  assign op3         = inst_i[24:19];
  assign rs1         = inst_i[18:14];
  assign imm         = inst_i[13];
  assign rs2         = inst_i[4:0];
  assign unused_bits = ^inst_i[12:5];
  assign is_store    = (op == OP_MEM) && (op3[5:2] == 4'b0001);

  // Flag decode and source extraction
  always_comb begin
    flags_o    = '0;
    src_o      = '0;
    flags_o.rd = rd;
    case (op)
      OP_CALL: begin
        flags_o.wr = 1'b1;
        flags_o.rd = 5'd15;
      end
      OP_FMT2: begin
        flags_o.wr   = (op2 == OP2_SETHI);
        src_o.icc_rd = (op2 == OP2_BICC);
      end
      OP_MEM: begin
        flags_o.wr     = !is_store;
        flags_o.wr_dbl = (op3 == OP3_LDD);
      end
      default: begin
        flags_o.wr     = !((op3[5:2] == 4'b1100) || (op3 == OP3_TICC) || (op3 == OP3_FLUSH));
        flags_o.icc_wr = (op3[5:4] == 2'b01) || ((op3 >= 6'b100000) && (op3 <= OP3_MULSCC));
        flags_o.y_wr   = op3 inside {6'b001010, 6'b001011, 6'b011010, 6'b011011,
                                     OP3_MULSCC, OP3_WRY};
        src_o.icc_rd   = (op3 == OP3_TICC);
        // RDY, MULScc, and UDIV/SDIV(cc) (op3[4:1] == 0111)
        src_o.y_rd     = (op3 == OP3_RDY) || (op3 == OP3_MULSCC) || (op3[4:1] == 4'b0111);
      end
    endcase
    // rs1/rs2 fields only exist in format-3 encodings
    if (op[1]) begin
      src_o.vld[0]  = 1'b1;
      src_o.regs[0] = rs1;
      src_o.vld[1]  = !imm;
      src_o.regs[1] = rs2;
    end
    if (is_store) begin
      src_o.vld[2]  = 1'b1;
      src_o.regs[2] = rd;
      src_o.vld[3]  = (op3 == OP3_STD);
      src_o.regs[3] = rd ^ 5'd1;
    end
    if (inst_i == NOP) begin
      src_o = '0;
    end
  end

endmodule

// File: rtl/sparc_decode_hazard_stage.sv
// SPARC V8 decode/interlock stage between fetch and execute.
// Holds one decoded instruction in a valid/ready register, interlocks it
// against N_STAGES downstream writers and pulses CWP updates on SAVE/RESTORE.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready/in_inst/in_pc          : fetch side handshake
//   flush                                    : drop held instruction
//   st_rd/st_wr/st_wr_dbl/st_icc_wr/st_y_wr  : per-stage writer info, stage 0 at LSB
//   out_valid/out_ready/out_*                : execute side handshake and decode
//   cwp_dec/cwp_inc                          : one-cycle pulses on SAVE/RESTORE fire
//   stall_cycles                             : hazard stall count
// Optional: define DECODE_STALL_CNT_EN to build the saturating stall counter;
// otherwise stall_cycles is tied to zero.
module sparc_decode_hazard_stage
  import sparc_decode_pkg::*;
#(
  parameter int unsigned INST_W   = 32,
  parameter int unsigned PC_W     = 64,
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     in_inst,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  flush,
  input  logic [N_STAGES*5-1:0] st_rd,
  input  logic [N_STAGES-1:0]   st_wr,
  input  logic [N_STAGES-1:0]   st_wr_dbl,
  input  logic [N_STAGES-1:0]   st_icc_wr,
  input  logic [N_STAGES-1:0]   st_y_wr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_W-1:0]     out_inst,
  output logic [PC_W-1:0]       out_pc,
  output logic [4:0]            out_rd,
  output logic                  out_wr,
  output logic                  out_wr_dbl,
  output logic                  out_icc_wr,
  output logic                  out_y_wr,
  output logic                  cwp_dec,
  output logic                  cwp_inc,
  output logic [CNT_W-1:0]      stall_cycles
);

  decode_flags_t     dec_flags;
  src_list_t         dec_src;
  logic              buf_valid_q, buf_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  decode_flags_t     flags_q, flags_d;
  src_list_t         src_q, src_d;
  logic              hazard;
  logic              accept;
  logic              fire;

  sparc_decode_classify u_classify (
    .inst_i  (in_inst),
    .flags_o (dec_flags),
    .src_o   (dec_src)
  );

  assign out_valid = buf_valid_q & ~hazard & ~flush;
  assign fire      = out_valid & out_ready;
  assign in_ready  = ~flush & (~buf_valid_q | fire);
  assign accept    = in_valid & in_ready;

  // Interlock OR-tree over all writer stages and source slots
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      for (int unsigned j = 0; j < N_SRC; j++) begin
        if (src_q.vld[j] && (src_q.regs[j] != 5'd0)) begin
          if ((src_q.regs[j] == st_rd[k*5 +: 5]) && st_wr[k] && (st_rd[k*5 +: 5] != 5'd0))
            hazard = 1'b1;
          // Double-word writer also covers the next register, wrapping at 31
          if ((src_q.regs[j] == 5'(st_rd[k*5 +: 5] + 5'd1)) && st_wr_dbl[k])
            hazard = 1'b1;
        end
      end
      if (src_q.icc_rd && st_icc_wr[k]) hazard = 1'b1;
      if (src_q.y_rd && st_y_wr[k])     hazard = 1'b1;
    end
  end

  // Pipeline register next state; flush wins over capture
  always_comb begin
    buf_valid_d = buf_valid_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    src_d       = src_q;
    if (flush) begin
      buf_valid_d = 1'b0;
    end else if (accept) begin
      buf_valid_d = 1'b1;
      inst_d      = in_inst;
      pc_d        = in_pc;
      flags_d     = dec_flags;
      src_d       = dec_src;
    end else if (fire) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      inst_q      <= '0;
      pc_q        <= '0;
      flags_q     <= '0;
      src_q       <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      flags_q     <= flags_d;
      src_q       <= src_d;
    end
  end

  assign out_inst   = inst_q;
  assign out_pc     = pc_q;
  assign out_rd     = flags_q.rd;
  assign out_wr     = flags_q.wr;
  assign out_wr_dbl = flags_q.wr_dbl;
  assign out_icc_wr = flags_q.icc_wr;
  assign out_y_wr   = flags_q.y_wr;
  assign cwp_dec    = fire && (inst_q[31:30] == OP_ARITH) && (inst_q[24:19] == OP3_SAVE);
  assign cwp_inc    = fire && (inst_q[31:30] == OP_ARITH) && (inst_q[24:19] == OP3_RESTORE);

`ifdef DECODE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles a held instruction is blocked by a hazard
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (buf_valid_q && hazard && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sparc_decode_hazard_stage.sv
// Table-driven bench for sparc_decode_hazard_stage with a decode scoreboard.
module tb_sparc_decode_hazard_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        flush;
  logic [14:0] st_rd;
  logic [2:0]  st_wr, st_wr_dbl, st_icc_wr, st_y_wr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_wr, out_wr_dbl, out_icc_wr, out_y_wr;
  logic        cwp_dec, cwp_inc;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  sparc_decode_hazard_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .st_rd(st_rd), .st_wr(st_wr), .st_wr_dbl(st_wr_dbl),
    .st_icc_wr(st_icc_wr), .st_y_wr(st_y_wr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_rd(out_rd), .out_wr(out_wr), .out_wr_dbl(out_wr_dbl), .out_icc_wr(out_icc_wr),
    .out_y_wr(out_y_wr), .cwp_dec(cwp_dec), .cwp_inc(cwp_inc), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        vld;
    logic [31:0] inst;
    logic        flush;
    logic        ordy;
    logic [14:0] st_rd;
    logic [2:0]  st_wr, st_dbl, st_icc, st_y;
    logic [3:0]  exp;      // {in_ready, out_valid, cwp_dec, cwp_inc}
    int          stall;    // expected count when the counter is built
  } row_t;

  row_t           rows[$];
  logic [104:0]   sb[$];
  int             nvec = 0;
  int             nerr = 0;

  logic [31:0] A1, A2, A3, B1, C1, C2, C3, D1, E1, F1, G1, H1, I1, I2, I3, J1, J2, NOPI;

  function automatic logic [31:0] fmt3(input logic [1:0] op, input logic [4:0] rd,
                                       input logic [5:0] op3, input logic [4:0] rs1,
                                       input logic i, input logic [12:0] lo);
    return {op, rd, op3, rs1, i, lo};
  endfunction

  function automatic row_t mk(input logic vld, input logic [31:0] inst, input logic fl,
                              input logic ordy, input logic [14:0] srd, input logic [2:0] swr,
                              input logic [2:0] sdbl, input logic [2:0] sicc, input logic [2:0] sy,
                              input logic [3:0] exp, input int stall);
    row_t r;
    r.vld = vld; r.inst = inst; r.flush = fl; r.ordy = ordy; r.st_rd = srd;
    r.st_wr = swr; r.st_dbl = sdbl; r.st_icc = sicc; r.st_y = sy; r.exp = exp; r.stall = stall;
    return r;
  endfunction

  // Reference decode: {inst, pc, rd, wr, wr_dbl, icc_wr, y_wr}
  function automatic logic [104:0] model(input logic [31:0] inst, input logic [63:0] pc);
    logic [1:0] op;
    logic [5:0] op3;
    logic [4:0] rd;
    logic       wr, dbl, icc, y;
    op  = inst[31:30];
    op3 = inst[24:19];
    rd  = (op == 2'b01) ? 5'd15 : inst[29:25];
    wr = 1'b0; dbl = 1'b0; icc = 1'b0; y = 1'b0;
    case (op)
      2'b01: wr = 1'b1;
      2'b00: wr = (inst[24:22] == 3'b100);
      2'b11: begin
        wr  = !((op3 >= 6'h04) && (op3 <= 6'h07));
        dbl = (op3 == 6'h03);
      end
      default: begin
        wr  = !(((op3 >= 6'h30) && (op3 <= 6'h33)) || (op3 == 6'h3A) || (op3 == 6'h3B));
        icc = (op3 >= 6'h10) && (op3 <= 6'h24);
        y   = op3 inside {6'h0A, 6'h0B, 6'h1A, 6'h1B, 6'h24, 6'h30};
      end
    endcase
    return {inst, pc, rd, wr, dbl, icc, y};
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_stall(input int s);
`ifdef DECODE_STALL_CNT_EN
    return s;
`else
    return (s < 0) ? s : 0;
`endif
  endfunction

  task automatic check_reset();
    cmp("rst_in_ready", 128'(in_ready), 128'(1));
    cmp("rst_out_valid", 128'(out_valid), 128'(0));
    cmp("rst_fields", 128'({out_inst, out_pc, out_rd, out_wr, out_wr_dbl, out_icc_wr, out_y_wr}), 128'(0));
    cmp("rst_cwp", 128'({cwp_dec, cwp_inc}), 128'(0));
    cmp("rst_stall", 128'(stall_cycles), 128'(0));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    st_rd = '0; st_wr = '0; st_wr_dbl = '0; st_icc_wr = '0; st_y_wr = '0;

    A1 = fmt3(2'd2, 5'd1, 6'd0, 5'd2, 1'b0, 13'd3);
    A2 = fmt3(2'd2, 5'd4, 6'd0, 5'd5, 1'b0, 13'd6);
    A3 = fmt3(2'd2, 5'd7, 6'd0, 5'd8, 1'b0, 13'd9);
    B1 = fmt3(2'd2, 5'd10, 6'd0, 5'd3, 1'b0, 13'd11);
    C1 = fmt3(2'd2, 5'd1, 6'd0, 5'd0, 1'b0, 13'd0);
    C2 = fmt3(2'd2, 5'd2, 6'd0, 5'd5, 1'b0, 13'd0);
    C3 = fmt3(2'd2, 5'd3, 6'd0, 5'd0, 1'b1, 13'd4);
    D1 = fmt3(2'd2, 5'd5, 6'b101000, 5'd0, 1'b0, 13'd0);
    E1 = fmt3(2'd3, 5'd6, 6'b000111, 5'd0, 1'b0, 13'd0);
    F1 = {2'b00, 1'b0, 4'b1001, 3'b010, 22'd4};
    G1 = fmt3(2'd2, 5'd14, 6'b111100, 5'd14, 1'b1, 13'h1FA0);
    H1 = fmt3(2'd2, 5'd0, 6'b111101, 5'd0, 1'b0, 13'd0);
    I1 = fmt3(2'd2, 5'd1, 6'd0, 5'd9, 1'b0, 13'd0);
    I2 = fmt3(2'd2, 5'd2, 6'd0, 5'd10, 1'b0, 13'd0);
    I3 = fmt3(2'd2, 5'd3, 6'd0, 5'd11, 1'b0, 13'd0);
    J1 = fmt3(2'd2, 5'd20, 6'd0, 5'd21, 1'b0, 13'd22);
    J2 = fmt3(2'd2, 5'd23, 6'd0, 5'd24, 1'b0, 13'd25);
    NOPI = 32'h0100_0000;

    // back-to-back independent ADDs
    rows.push_back(mk(1'b1, A1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 0));
    rows.push_back(mk(1'b1, A2, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 0));
    rows.push_back(mk(1'b1, A3, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 0));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 0));
    // rs1=r3 against stage-1 writer for 2 cycles; ready rises with hazard clearing
    rows.push_back(mk(1'b1, B1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 0));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, {5'd0, 5'd3, 5'd0}, 3'b010, 3'b000, 3'b000, 3'b000, 4'b0000, 0));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, {5'd0, 5'd3, 5'd0}, 3'b010, 3'b000, 3'b000, 3'b000, 4'b0000, 1));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 2));
    // register pair wrap and immediate rs2
    rows.push_back(mk(1'b1, C1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 2));
    rows.push_back(mk(1'b1, C2, 1'b0, 1'b1, {5'd0, 5'd0, 5'd31}, 3'b001, 3'b001, 3'b000, 3'b000, 4'b1100, 2));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, {5'd0, 5'd0, 5'd4}, 3'b001, 3'b001, 3'b000, 3'b000, 4'b0000, 2));
    rows.push_back(mk(1'b1, C3, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 3));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, {5'd0, 5'd0, 5'd4}, 3'b001, 3'b000, 3'b000, 3'b000, 4'b1100, 3));
    // RDY vs Y writer, STD odd half vs stage-2 writer
    rows.push_back(mk(1'b1, D1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 3));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b100, 4'b0000, 3));
    rows.push_back(mk(1'b1, E1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 4));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, {5'd7, 5'd0, 5'd0}, 3'b100, 3'b000, 3'b000, 3'b000, 4'b0000, 4));
    // BNE vs icc writer, then SAVE / RESTORE pulses
    rows.push_back(mk(1'b1, F1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 5));
    rows.push_back(mk(1'b1, G1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b100, 3'b000, 4'b0000, 5));
    rows.push_back(mk(1'b1, G1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 6));
    rows.push_back(mk(1'b1, H1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1110, 6));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1101, 6));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 6));
    // NOP with every writer active
    rows.push_back(mk(1'b1, NOPI, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 6));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1100, 6));
    // flush while stalled, then flush on empty buffer
    rows.push_back(mk(1'b1, I1, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 6));
    rows.push_back(mk(1'b1, I2, 1'b0, 1'b1, {5'd0, 5'd0, 5'd9}, 3'b001, 3'b000, 3'b000, 3'b000, 4'b0000, 6));
    rows.push_back(mk(1'b1, I2, 1'b1, 1'b1, {5'd0, 5'd0, 5'd9}, 3'b001, 3'b000, 3'b000, 3'b000, 4'b0000, 7));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 7));
    rows.push_back(mk(1'b1, I3, 1'b1, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0000, 7));
    rows.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 7));
    // backpressure for 3 cycles with a full buffer
    rows.push_back(mk(1'b1, J1, 1'b0, 1'b0, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1000, 7));
    rows.push_back(mk(1'b1, J2, 1'b0, 1'b0, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0100, 7));
    rows.push_back(mk(1'b1, J2, 1'b0, 1'b0, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0100, 7));
    rows.push_back(mk(1'b1, J2, 1'b0, 1'b0, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0100, 7));
    rows.push_back(mk(1'b1, J2, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1100, 7));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset();

    for (int i = 0; i < rows.size(); i++) begin
      logic [63:0] pc;
      @(posedge clk);
      #1;
      pc        = 64'h4000 + 64'(i) * 64'd4;
      in_valid  = rows[i].vld;
      in_inst   = rows[i].inst;
      in_pc     = pc;
      flush     = rows[i].flush;
      out_ready = rows[i].ordy;
      st_rd     = rows[i].st_rd;
      st_wr     = rows[i].st_wr;
      st_wr_dbl = rows[i].st_dbl;
      st_icc_wr = rows[i].st_icc;
      st_y_wr   = rows[i].st_y;
      @(negedge clk);
      cmp($sformatf("r%0d_in_ready", i), 128'(in_ready), 128'(rows[i].exp[3]));
      cmp($sformatf("r%0d_out_valid", i), 128'(out_valid), 128'(rows[i].exp[2]));
      cmp($sformatf("r%0d_cwp", i), 128'({cwp_dec, cwp_inc}), 128'(rows[i].exp[1:0]));
      cmp($sformatf("r%0d_stall", i), 128'(stall_cycles), 128'(exp_stall(rows[i].stall)));
      if (sb.size() != 0)
        cmp($sformatf("r%0d_held", i),
            128'({out_inst, out_pc, out_rd, out_wr, out_wr_dbl, out_icc_wr, out_y_wr}), 128'(sb[0]));
      if (rows[i].flush) begin
        sb.delete();
      end else begin
        if (rows[i].exp[2] && rows[i].ordy && (sb.size() != 0)) void'(sb.pop_front());
        if (rows[i].vld && rows[i].exp[3]) sb.push_back(model(rows[i].inst, pc));
      end
    end

    // reset in the middle of a stall
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1; st_rd = {5'd0, 5'd0, 5'd24}; st_wr = 3'b001;
    @(negedge clk);
    cmp("mid_out_valid", 128'(out_valid), 128'(0));
    cmp("mid_in_ready", 128'(in_ready), 128'(0));
    if (sb.size() != 0)
      cmp("mid_held", 128'({out_inst, out_pc, out_rd, out_wr, out_wr_dbl, out_icc_wr, out_y_wr}),
          128'(sb[0]));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    cmp("mid_stall", 128'(stall_cycles), 128'(exp_stall(8)));
    @(posedge clk);
    #1;
    reset = 1'b0; st_wr = 3'b000; st_rd = '0;
    @(negedge clk);
    check_reset();
    sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
